// File: rtl/sprite_pixel_fetcher.sv
// Sprite tile-row fetcher: reads both bitplanes for each scanner match and merges the
// eight pixels into the sprite shifter under DMG or CGB priority rules.
module sprite_pixel_fetcher #(
  parameter int SHIFT_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ce,
  input  logic        isGBC_game,
  input  logic        lcd_on,
  input  logic        line_start,
  input  logic        sprite_fetch,
  input  logic [10:0] sprite_addr,
  input  logic [7:0]  sprite_attr,
  input  logic [3:0]  sprite_index,
  output logic        sprite_fetch_done,
  output logic        fetch_busy,
  output logic [12:0] vram_addr,
  output logic        vram_bank,
  output logic        vram_rd,
  input  logic [7:0]  vram_data,
  input  logic        shift,
  output logic [1:0]  spr_color,
  output logic [2:0]  spr_pal,
  output logic        spr_bg_prio
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_OAM0  = 3'd1,
    S_OAM1  = 3'd2,
    S_LO    = 3'd3,
    S_HI    = 3'd4,
    S_MERGE = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  state_t      state_r, state_next_s;
  logic [10:0] addr_r;
  logic [7:0]  attr_r;
  logic [3:0]  idx_r;
  logic [7:0]  lo_r;

  logic [1:0]  color_r [SHIFT_DEPTH];
  logic        prio_r  [SHIFT_DEPTH];
  logic [2:0]  pal_r   [SHIFT_DEPTH];
  logic [3:0]  index_r [SHIFT_DEPTH];

  logic [7:0]  lo_px_s, hi_px_s;
  logic [1:0]  new_color_s [SHIFT_DEPTH];
  logic        wr_s        [SHIFT_DEPTH];
  logic [2:0]  new_pal_s;
  logic        clear_s;

  function automatic logic [7:0] rev8(input logic [7:0] v);
    for (int i = 0; i < 8; i++) rev8[i] = v[7-i];
  endfunction

  assign clear_s = !reset_n || !lcd_on;

  // Next-state logic; sprite_fetch low before DONE aborts without merging.
  always_comb begin
    state_next_s = state_r;
    if (line_start) begin
      state_next_s = S_IDLE;
    end else begin
      case (state_r)
        S_IDLE:  state_next_s = sprite_fetch ? S_OAM0  : S_IDLE;
        S_OAM0:  state_next_s = sprite_fetch ? S_OAM1  : S_IDLE;
        S_OAM1:  state_next_s = sprite_fetch ? S_LO    : S_IDLE;
        S_LO:    state_next_s = sprite_fetch ? S_HI    : S_IDLE;
        S_HI:    state_next_s = sprite_fetch ? S_MERGE : S_IDLE;
        S_MERGE: state_next_s = sprite_fetch ? S_DONE  : S_IDLE;
        S_DONE:  state_next_s = sprite_fetch ? S_DONE  : S_IDLE;
        default: state_next_s = S_IDLE;
      endcase
    end
  end

  // State register and per-sprite capture registers.
  always_ff @(posedge clk) begin
    if (clear_s) begin
      state_r <= S_IDLE;
      addr_r  <= 11'd0;
      attr_r  <= 8'd0;
      idx_r   <= 4'd0;
      lo_r    <= 8'd0;
    end else if (ce) begin
      state_r <= state_next_s;
      if (state_r == S_LO) begin
        addr_r <= sprite_addr;
        attr_r <= sprite_attr;
        idx_r  <= sprite_index;
      end else begin
        addr_r <= addr_r;
        attr_r <= attr_r;
        idx_r  <= idx_r;
      end
      lo_r <= (state_r == S_HI) ? vram_data : lo_r;
    end else begin
      state_r <= state_r;
    end
  end

  // Pixel decode and per-entry write enable; hi plane comes straight off the bus in MERGE.
  always_comb begin
    lo_px_s   = attr_r[5] ? lo_r : rev8(lo_r);
    hi_px_s   = attr_r[5] ? vram_data : rev8(vram_data);
    new_pal_s = isGBC_game ? attr_r[2:0] : {2'b00, attr_r[4]};
    for (int p = 0; p < SHIFT_DEPTH; p++) begin
      new_color_s[p] = {hi_px_s[p], lo_px_s[p]};
      wr_s[p] = (new_color_s[p] != 2'd0) &&
                ((color_r[p] == 2'd0) || (isGBC_game && (idx_r < index_r[p])));
    end
  end

  // Sprite shifter: clear, merge a fetched row, or advance one pixel.
  always_ff @(posedge clk) begin
    for (int i = 0; i < SHIFT_DEPTH; i++) begin
      if (clear_s || (ce && line_start)) begin
        color_r[i] <= 2'd0;
        prio_r[i]  <= 1'b0;
        pal_r[i]   <= 3'd0;
        index_r[i] <= 4'd15;
      end else if (ce && state_r == S_MERGE && sprite_fetch) begin
        if (wr_s[i]) begin
          color_r[i] <= new_color_s[i];
          prio_r[i]  <= attr_r[7];
          pal_r[i]   <= new_pal_s;
          index_r[i] <= idx_r;
        end else begin
          color_r[i] <= color_r[i];
        end
      end else if (ce && shift && state_r == S_IDLE) begin
        if (i == SHIFT_DEPTH - 1) begin
          color_r[i] <= 2'd0;
          prio_r[i]  <= 1'b0;
          pal_r[i]   <= 3'd0;
          index_r[i] <= 4'd15;
        end else begin
          color_r[i] <= color_r[i+1];
          prio_r[i]  <= prio_r[i+1];
          pal_r[i]   <= pal_r[i+1];
          index_r[i] <= index_r[i+1];
        end
      end else begin
        color_r[i] <= color_r[i];
      end
    end
  end

  // VRAM request: low plane in LO, high plane in HI.
  always_comb begin
    vram_addr = 13'd0;
    vram_rd   = 1'b0;
    vram_bank = 1'b0;
    case (state_r)
      S_LO: begin
        vram_addr = {1'b0, sprite_addr, 1'b0};
        vram_rd   = 1'b1;
        vram_bank = isGBC_game & sprite_attr[3];
      end
      S_HI: begin
        vram_addr = {1'b0, addr_r, 1'b1};
        vram_rd   = 1'b1;
        vram_bank = isGBC_game & attr_r[3];
      end
      default: begin
        vram_addr = 13'd0;
      end
    endcase
  end

  assign sprite_fetch_done = (state_r == S_DONE);
  assign fetch_busy        = (state_r != S_IDLE);
  assign spr_color         = color_r[0];
  assign spr_pal           = pal_r[0];
  assign spr_bg_prio       = prio_r[0];

endmodule

// File: tb/tb_sprite_pixel_fetcher.sv
// Directed bench for sprite_pixel_fetcher with a small VRAM model answering one ce late.
module tb_sprite_pixel_fetcher;

  logic        clk = 1'b0;
  logic        reset_n, ce, isGBC_game, lcd_on, line_start, sprite_fetch, shift;
  logic [10:0] sprite_addr;
  logic [7:0]  sprite_attr;
  logic [3:0]  sprite_index;
  logic        sprite_fetch_done, fetch_busy, vram_bank, vram_rd, spr_bg_prio;
  logic [12:0] vram_addr;
  logic [7:0]  vram_data = 8'd0;
  logic [1:0]  spr_color;
  logic [2:0]  spr_pal;

  logic [7:0]  mem [0:8191];
  int          checks = 0;
  int          failures = 0;
  int          lat;
  logic [12:0] seen_addr;
  logic        seen_bank;

  always #5 clk = ~clk;

  always @(posedge clk) if (ce && vram_rd) vram_data <= mem[vram_addr];

  sprite_pixel_fetcher dut (
    .clk(clk), .reset_n(reset_n), .ce(ce), .isGBC_game(isGBC_game), .lcd_on(lcd_on),
    .line_start(line_start), .sprite_fetch(sprite_fetch), .sprite_addr(sprite_addr),
    .sprite_attr(sprite_attr), .sprite_index(sprite_index),
    .sprite_fetch_done(sprite_fetch_done), .fetch_busy(fetch_busy), .vram_addr(vram_addr),
    .vram_bank(vram_bank), .vram_rd(vram_rd), .vram_data(vram_data), .shift(shift),
    .spr_color(spr_color), .spr_pal(spr_pal), .spr_bg_prio(spr_bg_prio)
  );

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_line();
    line_start = 1'b1;
    step();
    line_start = 1'b0;
  endtask

  // Full handshake: raise fetch, wait for done, hold one ce, then release.
  task automatic do_fetch(input logic [10:0] a, input logic [7:0] at, input logic [3:0] ix,
                          input logic [7:0] lo, input logic [7:0] hi,
                          output int l, output logic [12:0] sa, output logic sb);
    logic got_rd;
    mem[{1'b0, a, 1'b0}] = lo;
    mem[{1'b0, a, 1'b1}] = hi;
    sprite_addr = a; sprite_attr = at; sprite_index = ix; sprite_fetch = 1'b1;
    l = -1; sa = 13'd0; sb = 1'b0; got_rd = 1'b0;
    for (int c = 1; c <= 20 && l < 0; c++) begin
      step();
      if (vram_rd && !got_rd) begin
        got_rd = 1'b1; sa = vram_addr; sb = vram_bank;
      end
      if (sprite_fetch_done) l = c;
    end
    step();
    check_eq("done_held", 16'(sprite_fetch_done), 16'd1);
    sprite_fetch = 1'b0;
    step();
    check_eq("idle_after_done", 16'(fetch_busy), 16'd0);
  endtask

  // Entry i expected at exp[2i+:2]; shifts the whole row out.
  task automatic read_colors(input string tag, input logic [15:0] exp);
    for (int i = 0; i < 8; i++) begin
      check_eq($sformatf("%s_e%0d", tag, i), 16'(spr_color), 16'(exp[2*i +: 2]));
      shift = 1'b1;
      step();
      shift = 1'b0;
    end
    check_eq($sformatf("%s_empty", tag), 16'(spr_color), 16'd0);
  endtask

  initial begin
    reset_n = 1'b0; ce = 1'b1; isGBC_game = 1'b0; lcd_on = 1'b1; line_start = 1'b0;
    sprite_fetch = 1'b0; shift = 1'b0; sprite_addr = 11'd0; sprite_attr = 8'd0;
    sprite_index = 4'd0;
    step(); step();
    check_eq("rst_done",  16'(sprite_fetch_done), 16'd0);
    check_eq("rst_busy",  16'(fetch_busy), 16'd0);
    check_eq("rst_rd",    16'(vram_rd), 16'd0);
    check_eq("rst_addr",  16'(vram_addr), 16'd0);
    check_eq("rst_color", 16'(spr_color), 16'd0);
    check_eq("rst_pal",   16'(spr_pal), 16'd0);
    check_eq("rst_prio",  16'(spr_bg_prio), 16'd0);
    reset_n = 1'b1;

    // Without ce nothing advances.
    ce = 1'b0; sprite_fetch = 1'b1;
    step(); step(); step();
    check_eq("ce_gate_busy", 16'(fetch_busy), 16'd0);
    ce = 1'b1; sprite_fetch = 1'b0;
    step();

    // DMG basic row, palette bit set, bank bit ignored.
    do_fetch(11'h123, 8'h18, 4'd0, 8'hF0, 8'hCC, lat, seen_addr, seen_bank);
    check_eq("dmg_latency", 16'(lat), 16'd6);
    check_eq("dmg_lo_addr", 16'(seen_addr), 16'h0246);
    check_eq("dmg_bank",    16'(seen_bank), 16'd0);
    check_eq("dmg_pal",     16'(spr_pal), 16'd1);
    check_eq("dmg_prio",    16'(spr_bg_prio), 16'd0);
    read_colors("dmg_row", 16'h0A5F);

    // X flip.
    clear_line();
    do_fetch(11'h010, 8'h30, 4'd1, 8'hF0, 8'hCC, lat, seen_addr, seen_bank);
    read_colors("xflip_row", 16'hF5A0);

    // DMG overlap: first-fetched sprite keeps priority.
    clear_line();
    do_fetch(11'h020, 8'h00, 4'd2, 8'hFF, 8'h00, lat, seen_addr, seen_bank);
    do_fetch(11'h021, 8'h8D, 4'd0, 8'hFF, 8'hFF, lat, seen_addr, seen_bank);
    check_eq("dmg_ovl_prio", 16'(spr_bg_prio), 16'd0);
    read_colors("dmg_ovl", 16'h5555);

    // CGB overlap: lower slot wins; a higher slot cannot then displace it.
    isGBC_game = 1'b1;
    clear_line();
    do_fetch(11'h020, 8'h00, 4'd2, 8'hFF, 8'h00, lat, seen_addr, seen_bank);
    do_fetch(11'h021, 8'h8D, 4'd0, 8'hFF, 8'hFF, lat, seen_addr, seen_bank);
    check_eq("cgb_bank", 16'(seen_bank), 16'd1);
    check_eq("cgb_pal",  16'(spr_pal), 16'd5);
    check_eq("cgb_prio", 16'(spr_bg_prio), 16'd1);
    do_fetch(11'h022, 8'h02, 4'd1, 8'h00, 8'hFF, lat, seen_addr, seen_bank);
    read_colors("cgb_ovl", 16'hFFFF);

    // Transparent pixels never overwrite, even from a lower slot.
    clear_line();
    do_fetch(11'h030, 8'h00, 4'd5, 8'h00, 8'hFF, lat, seen_addr, seen_bank);
    do_fetch(11'h031, 8'h00, 4'd1, 8'h00, 8'h00, lat, seen_addr, seen_bank);
    check_eq("transp_keep", 16'(spr_color), 16'd2);

    // Abort in HI leaves the shifter untouched.
    mem[13'h080] = 8'hFF; mem[13'h081] = 8'hFF;
    sprite_addr = 11'h040; sprite_attr = 8'h00; sprite_index = 4'd0; sprite_fetch = 1'b1;
    step(); step(); step(); step();
    check_eq("hi_busy", 16'(fetch_busy), 16'd1);
    check_eq("hi_rd",   16'(vram_rd), 16'd1);
    check_eq("hi_addr", 16'(vram_addr), 16'h0081);
    sprite_fetch = 1'b0;
    step();
    check_eq("abort_busy", 16'(fetch_busy), 16'd0);
    check_eq("abort_done", 16'(sprite_fetch_done), 16'd0);
    read_colors("abort_row", 16'hAAAA);

    // Reset in MERGE.
    do_fetch(11'h050, 8'h00, 4'd3, 8'hFF, 8'h00, lat, seen_addr, seen_bank);
    check_eq("pre_rst_color", 16'(spr_color), 16'd1);
    sprite_addr = 11'h051; sprite_fetch = 1'b1;
    step(); step(); step(); step(); step();
    check_eq("merge_busy", 16'(fetch_busy), 16'd1);
    reset_n = 1'b0;
    step();
    check_eq("mrst_busy",  16'(fetch_busy), 16'd0);
    check_eq("mrst_done",  16'(sprite_fetch_done), 16'd0);
    check_eq("mrst_color", 16'(spr_color), 16'd0);
    reset_n = 1'b1; sprite_fetch = 1'b0;
    step();

    // line_start during a fetch forces IDLE.
    sprite_fetch = 1'b1;
    step(); step(); step();
    line_start = 1'b1;
    step();
    line_start = 1'b0;
    check_eq("ls_abort_busy", 16'(fetch_busy), 16'd0);
    sprite_fetch = 1'b0;
    step(); step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
